johnson_decoder: RTL and testbench
==================================

JOHNSON_DECODER -- requirements
Module: johnson_decoder

Interface
REQ-001 Parameter WIDTH, default 4: Johnson code width; legal range 2..16.
REQ-002 Parameter LOCK_CNT, default 3: number of consecutive correct successors needed to enter LOCKED; range 1..15.
REQ-003 IDXW is derived as $clog2(2*WIDTH): index width, 3 when WIDTH=4.
REQ-004 clk  input  1  rising-edge clock; one clock domain only.
REQ-005 clear  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  code is sampled on this edge.
REQ-007 code  input  WIDTH  Johnson-coded count from the counter under observation.
REQ-008 out_valid  output  1  registered copy of in_valid.
REQ-009 index  output  IDXW  binary position of the sampled code, 0..2*WIDTH-1.
REQ-010 illegal  output  1  sampled code is not one of the 2*WIDTH Johnson patterns.
REQ-011 seq_err  output  1  one-cycle pulse when a sequence error is detected while LOCKED.
REQ-012 locked  output  1  level that is high while the FSM is in LOCKED.
REQ-013 err_count  output  8  saturating count of seq_err pulses.

Function
REQ-014 The reference sequence is: shift right, new MSB = ~old LSB, starting from all-zeros; for WIDTH=4 it is 0000,1000,1100,1110,1111,0111,0011,0001, then wraps to 0000.
REQ-015 Legal codes are ones-from-MSB (1..10..0, all-ones included) or zeros-from-MSB (0..01..1, all-zeros included); every other code is illegal.
REQ-016 Decode rule: if code[WIDTH-1]=1, index = popcount(code); otherwise index = (2*WIDTH - popcount(code)) mod 2*WIDTH, so 0000 decodes to 0.
REQ-017 Illegal codes force index=0 and illegal=1.
REQ-018 Latency: out_valid, index and illegal are registered and appear exactly 1 cycle after the sampling edge; when in_valid=0 they hold their previous values and out_valid=0.
REQ-019 Successor of index i is (i+1) mod 2*WIDTH; the wrap from 2*WIDTH-1 to 0 counts as correct.
REQ-020 The FSM has three states: HUNT, SYNC and LOCKED; it holds an internal prev index and a match counter; only cycles with in_valid=1 affect it.
REQ-021 In HUNT: a legal sample sets prev=index, match=0 and moves to SYNC; an illegal sample stays in HUNT.
REQ-022 In SYNC, on a correct successor: prev updates and match increments; when match reaches LOCK_CNT the FSM moves to LOCKED.
REQ-023 In SYNC, on a legal non-successor: prev=new index, match=0, remain in SYNC.
REQ-024 In SYNC, on an illegal sample: move to HUNT; seq_err is not pulsed outside LOCKED.
REQ-025 In LOCKED, on a correct successor: prev updates and the FSM stays in LOCKED.
REQ-026 In LOCKED, on any other sample (repeat, jump or illegal): seq_err=1 for one cycle, err_count increments, and locked drops on the same edge.
REQ-027 After the LOCKED error of REQ-026: the next state is SYNC with prev=new index and match=0 if the sample was legal, or HUNT if it was illegal.
REQ-028 seq_err and locked are registered and aligned with out_valid of the offending sample.
REQ-029 err_count saturates at 255 and never wraps.
REQ-030 The clear edge has priority over a simultaneous in_valid; that sample is discarded.

Reset
REQ-031 While clear=1 at a rising clk edge, the block resets: state=HUNT, prev=0, match=0, out_valid=0, index=0, illegal=0, seq_err=0, locked=0, err_count=0.
REQ-032 Asserting clear mid-sequence, including while LOCKED, takes effect at the next edge; lock is reacquired only through HUNT and SYNC.

Verification
REQ-033 Valid every cycle, codes 0000,1000,1100,1110,1111 -> index 0,1,2,3,4 with 1-cycle latency; locked rises on the 4th sample's output (LOCK_CNT=3).
REQ-034 Free-running sequence through 0001 -> 0000 -> index 7 then 0; locked stays 1 and seq_err stays 0 across the wrap.
REQ-035 While LOCKED, code 1010 -> illegal=1, index=0, seq_err=1 for one cycle, err_count=1, locked=0, state HUNT.
REQ-036 While LOCKED at index 2, code 0111 (jump to 5) -> seq_err=1 and err_count increments; subsequent 0011,0001,0000 -> relock on the 3rd correct successor.
REQ-037 clear=1 together with in_valid=1 while LOCKED with err_count=5 -> next cycle all outputs 0 and err_count=0; 256 forced errors -> err_count holds at 255.

Source files
------------

// File: rtl/johnson_decoder.sv
// ----------------------------------------------------------------------------
// johnson_decoder
//
// Watches the output of a free-running Johnson (twisted-ring) counter,
// converts each sampled code to its binary position in the ring and checks
// that consecutive samples advance by exactly one position.
//
// The reference ring starts at all-zeros and shifts right with the new MSB
// taken from the inverted old LSB (WIDTH=4: 0000,1000,1100,1110,1111,0111,
// 0011,0001, then back to 0000).
//
// A three-state tracker (HUNT -> SYNC -> LOCKED) qualifies the stream: it
// needs LOCK_CNT consecutive correct successors before declaring lock, and
// while locked any repeat, jump or illegal code raises a one-cycle seq_err
// pulse and bumps a saturating error counter.
//
// Ports
//   clk        in   1     rising-edge clock
//   clear      in   1     synchronous active-high reset, beats in_valid
//   in_valid   in   1     sample code on this edge
//   code       in   WIDTH Johnson-coded count under observation
//   out_valid  out  1     registered copy of in_valid
//   index      out  IDXW  binary ring position of the last sample (0 if illegal)
//   illegal    out  1     last sample was not one of the 2*WIDTH ring codes
//   seq_err    out  1     one-cycle pulse on a sequence error while locked
//   locked     out  1     high while the tracker is in LOCKED
//   err_count  out  8     saturating count of seq_err pulses
//
// out_valid, index, illegal, seq_err and locked all appear one cycle after
// the sampling edge and are mutually aligned. When in_valid is low, index
// and illegal keep their previous values.
// ----------------------------------------------------------------------------
module johnson_decoder #(
   parameter  int WIDTH    = 4,
   parameter  int LOCK_CNT = 3,
   localparam int IDXW     = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] code,
   output logic             out_valid,
   output logic [IDXW-1:0]  index,
   output logic             illegal,
   output logic             seq_err,
   output logic             locked,
   output logic [7:0]       err_count
);

   // Match counter is wide enough for the largest supported LOCK_CNT (15).
   localparam int MW = 4;

   localparam logic [IDXW:0]   NCODES   = (IDXW+1)'(2*WIDTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2*WIDTH - 1);
   localparam logic [IDXW-1:0] ZERO_IDX = {IDXW{1'b0}};
   localparam logic [IDXW-1:0] ONE_IDX  = {{(IDXW-1){1'b0}}, 1'b1};
   localparam logic [MW-1:0]   LOCK_TGT = MW'(LOCK_CNT);
   localparam logic [MW-1:0]   MW_ZERO  = {MW{1'b0}};
   localparam logic [MW-1:0]   MW_ONE   = {{(MW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // -------------------------------------------------------------------------
   // Helper functions
   // -------------------------------------------------------------------------

   // Number of set bits in a code; result fits in IDXW because 2*WIDTH > WIDTH.
   function automatic logic [IDXW-1:0] popcount(input logic [WIDTH-1:0] c);
      logic [IDXW-1:0] cnt;
      cnt = {IDXW{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + {{(IDXW-1){1'b0}}, c[i]};
      end
      return cnt;
   endfunction

   // A ring code is a single run of ones followed by a single run of zeros
   // (or the reverse), so adjacent bits may differ at most once.
   function automatic logic is_ring_code(input logic [WIDTH-1:0] c);
      logic [IDXW:0] changes;
      changes = {(IDXW+1){1'b0}};
      for (int i = 0; i < WIDTH-1; i++) begin
         changes = changes + {{IDXW{1'b0}}, (c[i] ^ c[i+1])};
      end
      return (changes <= {{IDXW{1'b0}}, 1'b1});
   endfunction

   // Ring position of a legal code. MSB set means we are in the filling half
   // (position = number of ones); MSB clear means the draining half, counted
   // back from the wrap point. All-zeros maps to position 0, not 2*WIDTH.
   function automatic logic [IDXW-1:0] ring_index(input logic [WIDTH-1:0] c);
      logic [IDXW-1:0] pop;
      logic [IDXW:0]   diff;
      pop  = popcount(c);
      diff = NCODES - {1'b0, pop};
      if (c[WIDTH-1]) begin
         return pop;
      end else if (pop == ZERO_IDX) begin
         return ZERO_IDX;
      end else begin
         return diff[IDXW-1:0];
      end
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t          state_r;
   logic [IDXW-1:0] prev_r;
   logic [MW-1:0]   match_r;

   logic            legal_s;
   logic [IDXW-1:0] dec_index_s;
   logic [IDXW-1:0] succ_s;
   logic            is_succ_s;
   logic [MW-1:0]   match_nxt_s;

   // Decode the incoming code and work out whether it follows the previous sample.
   always_comb begin
      legal_s     = is_ring_code(code);
      dec_index_s = ZERO_IDX;
      if (legal_s) begin
         dec_index_s = ring_index(code);
      end else begin
         dec_index_s = ZERO_IDX;
      end

      // Wrap from the last position back to 0 counts as a correct step.
      succ_s = ZERO_IDX;
      if (prev_r == LAST_IDX) begin
         succ_s = ZERO_IDX;
      end else begin
         succ_s = prev_r + ONE_IDX;
      end

      is_succ_s   = legal_s && (dec_index_s == succ_s);
      match_nxt_s = match_r + MW_ONE;
   end

   // Registered outputs and the HUNT/SYNC/LOCKED tracker.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_r   <= ST_HUNT;
         prev_r    <= ZERO_IDX;
         match_r   <= MW_ZERO;
         out_valid <= 1'b0;
         index     <= ZERO_IDX;
         illegal   <= 1'b0;
         seq_err   <= 1'b0;
         locked    <= 1'b0;
         err_count <= 8'd0;
      end else begin
         out_valid <= in_valid;
         seq_err   <= 1'b0;

         if (in_valid) begin
            index   <= dec_index_s;
            illegal <= ~legal_s;

            case (state_r)
               ST_HUNT: begin
                  if (legal_s) begin
                     prev_r  <= dec_index_s;
                     match_r <= MW_ZERO;
                     state_r <= ST_SYNC;
                  end else begin
                     state_r <= ST_HUNT;
                  end
                  locked <= 1'b0;
               end

               ST_SYNC: begin
                  if (!legal_s) begin
                     match_r <= MW_ZERO;
                     state_r <= ST_HUNT;
                     locked  <= 1'b0;
                  end else if (is_succ_s) begin
                     prev_r  <= dec_index_s;
                     match_r <= match_nxt_s;
                     if (match_nxt_s == LOCK_TGT) begin
                        state_r <= ST_LOCKED;
                        locked  <= 1'b1;
                     end else begin
                        state_r <= ST_SYNC;
                        locked  <= 1'b0;
                     end
                  end else begin
                     // Legal but out of order: restart the qualification run here.
                     prev_r  <= dec_index_s;
                     match_r <= MW_ZERO;
                     state_r <= ST_SYNC;
                     locked  <= 1'b0;
                  end
               end

               ST_LOCKED: begin
                  if (is_succ_s) begin
                     prev_r  <= dec_index_s;
                     state_r <= ST_LOCKED;
                     locked  <= 1'b1;
                  end else begin
                     seq_err <= 1'b1;
                     locked  <= 1'b0;
                     if (err_count != 8'd255) begin
                        err_count <= err_count + 8'd1;
                     end else begin
                        err_count <= err_count;
                     end
                     // A legal code gives us a fresh anchor; an illegal one does not.
                     if (legal_s) begin
                        prev_r  <= dec_index_s;
                        match_r <= MW_ZERO;
                        state_r <= ST_SYNC;
                     end else begin
                        match_r <= MW_ZERO;
                        state_r <= ST_HUNT;
                     end
                  end
               end

               default: begin
                  prev_r  <= ZERO_IDX;
                  match_r <= MW_ZERO;
                  state_r <= ST_HUNT;
                  locked  <= 1'b0;
               end
            endcase
         end else begin
            index   <= index;
            illegal <= illegal;
         end
      end
   end

endmodule

// File: tb/tb_johnson_decoder.sv
// ----------------------------------------------------------------------------
// tb_johnson_decoder
//
// Directed scenarios followed by a randomized stream. Expected outputs come
// from a reference model that looks each code up in a table generated by
// running the ring's shift rule, and that tracks lock purely in terms of
// "how many correct successors in a row have we seen".
// ----------------------------------------------------------------------------
module tb_johnson_decoder;

   localparam int WIDTH    = 4;
   localparam int LOCK_CNT = 3;
   localparam int IDXW     = $clog2(2*WIDTH);
   localparam int NCODES   = 2*WIDTH;

   logic             clk = 1'b0;
   logic             clear;
   logic             in_valid;
   logic [WIDTH-1:0] code;
   logic             out_valid;
   logic [IDXW-1:0]  index;
   logic             illegal;
   logic             seq_err;
   logic             locked;
   logic [7:0]       err_count;

   int tests = 0;
   int fails = 0;

   // Ring table built from the shift rule, not from any decode formula.
   logic [WIDTH-1:0] seq_tab [NCODES];

   // Reference model state. m_mode: 0 = hunting, 1 = qualifying, 2 = locked.
   int m_mode;
   int m_prev;
   int m_streak;
   int m_errs;
   int e_valid;
   int e_index;
   int e_illegal;
   int e_seq;

   always #5 clk = ~clk;

   johnson_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT)) dut (
      .clk       (clk),
      .clear     (clear),
      .in_valid  (in_valid),
      .code      (code),
      .out_valid (out_valid),
      .index     (index),
      .illegal   (illegal),
      .seq_err   (seq_err),
      .locked    (locked),
      .err_count (err_count)
   );

   function automatic int lookup(input logic [WIDTH-1:0] c);
      for (int k = 0; k < NCODES; k++) begin
         if (seq_tab[k] == c) return k;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit clr, input bit v, input logic [WIDTH-1:0] c);
      int k;
      if (clr) begin
         m_mode = 0; m_prev = 0; m_streak = 0; m_errs = 0;
         e_valid = 0; e_index = 0; e_illegal = 0; e_seq = 0;
         return;
      end
      e_valid = v;
      e_seq   = 0;
      if (!v) return;
      k = lookup(c);
      e_illegal = (k < 0) ? 1 : 0;
      e_index   = (k < 0) ? 0 : k;
      if (m_mode == 0) begin
         if (k >= 0) begin
            m_prev = k; m_streak = 0; m_mode = 1;
         end
      end else if (m_mode == 1) begin
         if (k < 0) begin
            m_mode = 0;
         end else if (k == (m_prev + 1) % NCODES) begin
            m_prev = k;
            m_streak++;
            if (m_streak == LOCK_CNT) m_mode = 2;
         end else begin
            m_prev = k; m_streak = 0;
         end
      end else begin
         if (k >= 0 && k == (m_prev + 1) % NCODES) begin
            m_prev = k;
         end else begin
            e_seq = 1;
            if (m_errs < 255) m_errs++;
            if (k < 0) begin
               m_mode = 0;
            end else begin
               m_mode = 1; m_prev = k; m_streak = 0;
            end
         end
      end
   endtask

   // Drive one cycle, advance the model, then compare every output.
   task automatic step(input bit clr, input bit v, input logic [WIDTH-1:0] c);
      @(negedge clk);
      clear    = clr;
      in_valid = v;
      code     = c;
      @(posedge clk);
      model(clr, v, c);
      #1;
      check("out_valid", out_valid, e_valid);
      check("index",     index,     e_index);
      check("illegal",   illegal,   e_illegal);
      check("seq_err",   seq_err,   e_seq);
      check("locked",    locked,    (m_mode == 2) ? 1 : 0);
      check("err_count", err_count, m_errs);
   endtask

   // Reach lock (bounded), then inject a jump of +3 positions.
   task automatic force_error();
      for (int g = 0; g < 20 && m_mode != 2; g++) begin
         step(1'b0, 1'b1, seq_tab[(m_prev + 1) % NCODES]);
      end
      check("lock_reached", locked, 1);
      step(1'b0, 1'b1, seq_tab[(m_prev + 3) % NCODES]);
   endtask

   initial begin
      logic [WIDTH-1:0] s;
      int               r;

      s = '0;
      for (int k = 0; k < NCODES; k++) begin
         seq_tab[k] = s;
         s = {~s[0], s[WIDTH-1:1]};
      end

      clear = 1'b1; in_valid = 1'b0; code = '0;
      m_mode = 0; m_prev = 0; m_streak = 0; m_errs = 0;
      e_valid = 0; e_index = 0; e_illegal = 0; e_seq = 0;

      // Reset state
      step(1'b1, 1'b0, 4'b0000);
      step(1'b1, 1'b1, 4'b1111);
      check("rst_out_valid", out_valid, 0);
      check("rst_index",     index,     0);
      check("rst_locked",    locked,    0);
      check("rst_err_count", err_count, 0);

      // Basic decode and lock acquisition
      step(1'b0, 1'b1, 4'b0000); check("d0_index", index, 0);
      step(1'b0, 1'b1, 4'b1000); check("d1_index", index, 1);
      step(1'b0, 1'b1, 4'b1100); check("d2_index", index, 2); check("d2_locked", locked, 0);
      step(1'b0, 1'b1, 4'b1110); check("d3_index", index, 3); check("d3_locked", locked, 1);
      step(1'b0, 1'b1, 4'b1111); check("d4_index", index, 4);

      // Wrap through 0001 -> 0000 stays locked
      step(1'b0, 1'b1, 4'b0111); check("d5_index", index, 5);
      step(1'b0, 1'b1, 4'b0011);
      step(1'b0, 1'b1, 4'b0001); check("d7_index", index, 7);
      step(1'b0, 1'b1, 4'b0000); check("wrap_index", index, 0);
      check("wrap_locked", locked, 1); check("wrap_seq_err", seq_err, 0);

      // Hold behaviour on an idle cycle
      step(1'b0, 1'b0, 4'b1010); check("idle_index", index, 0); check("idle_valid", out_valid, 0);

      // Illegal code while locked
      step(1'b0, 1'b1, 4'b1010);
      check("ill_illegal", illegal, 1); check("ill_index", index, 0);
      check("ill_seq_err", seq_err, 1); check("ill_err_count", err_count, 1);
      check("ill_locked", locked, 0);
      step(1'b0, 1'b0, 4'b0000); check("ill_pulse_end", seq_err, 0);

      // Jump while locked at index 2, then relock on the 3rd successor
      step(1'b0, 1'b1, 4'b0011);
      step(1'b0, 1'b1, 4'b0001);
      step(1'b0, 1'b1, 4'b0000);
      step(1'b0, 1'b1, 4'b1000);
      step(1'b0, 1'b1, 4'b1100); check("j_locked_at2", locked, 1);
      step(1'b0, 1'b1, 4'b0111);
      check("j_seq_err", seq_err, 1); check("j_err_count", err_count, 2); check("j_index", index, 5);
      step(1'b0, 1'b1, 4'b0011); check("j_relock1", locked, 0);
      step(1'b0, 1'b1, 4'b0001); check("j_relock2", locked, 0);
      step(1'b0, 1'b1, 4'b0000); check("j_relock3", locked, 1);

      // Three more errors -> err_count 5, relock, then clear with in_valid
      force_error(); force_error(); force_error();
      check("five_errs", err_count, 5);
      for (int g = 0; g < 20 && m_mode != 2; g++) begin
         step(1'b0, 1'b1, seq_tab[(m_prev + 1) % NCODES]);
      end
      check("pre_clear_locked", locked, 1);
      step(1'b1, 1'b1, seq_tab[(m_prev + 1) % NCODES]);
      check("clr_out_valid", out_valid, 0); check("clr_index", index, 0);
      check("clr_illegal", illegal, 0); check("clr_seq_err", seq_err, 0);
      check("clr_locked", locked, 0); check("clr_err_count", err_count, 0);

      // Saturation of the error counter
      for (int n = 0; n < 258; n++) force_error();
      check("sat_err_count", err_count, 255);
      step(1'b1, 1'b0, 4'b0000);

      // Randomized stream
      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         if (r < 3)
            step(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         else if (r < 13)
            step(1'b0, 1'b0, 4'($urandom_range(0, 15)));
         else if (r < 23)
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)));
         else if (r < 30)
            step(1'b0, 1'b1, seq_tab[$urandom_range(0, NCODES-1)]);
         else
            step(1'b0, 1'b1, seq_tab[(m_prev + 1) % NCODES]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
